// File: rtl/display_sight_test_if.sv
// Key inputs and LED matrix / 7-segment drive of the visual-acuity tester.
// The slave modport is the tester itself; master is the board/bench side.
interface display_sight_test_if;
    logic [7:0] col_pin;
    logic [7:0] row_pin;
    logic [7:0] seg_sel;
    logic [7:0] seg_led;
    logic       KeyRESTART;
    logic       KeyLeft;
    logic       KeyRight;
    logic       KeyDown;
    logic       Keyup;

    modport master (
        output KeyRESTART, KeyLeft, KeyRight, KeyDown, Keyup,
        input  col_pin, row_pin, seg_sel, seg_led
    );

    modport slave (
        input  KeyRESTART, KeyLeft, KeyRight, KeyDown, Keyup,
        output col_pin, row_pin, seg_sel, seg_led
    );
endinterface

// File: rtl/display_sight_test.sv
// Tumbling-E acuity tester: draws an E on a scanned 8x8 matrix, grades direction
// answers, and shows the current acuity level on a multiplexed 7-segment display.
module display_sight_test #(
    parameter int unsigned SCAN_DIV  = 4,
    parameter int unsigned SEG_DIV   = 4,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic             sys_clk,
    input logic             sys_rst,
    display_sight_test_if.slave io
);
    localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SGW = (SEG_DIV > 1) ? $clog2(SEG_DIV) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_TEST, ST_PASS, ST_FAIL} state_t;
    typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN} dir_t;

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d, ans_dir;
    logic [2:0] level_q, level_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [4:0] key_raw, sync1_q, sync2_q, sync3_q, key_edge;
    logic       ans_one;

    // Key vector: {restart, left, right, up, down}
    assign key_raw  = {io.KeyRESTART, io.KeyLeft, io.KeyRight, io.Keyup, io.KeyDown};
    assign key_edge = sync2_q & ~sync3_q;
    assign ans_one  = $onehot(key_edge[3:0]);
    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        ans_dir = DIR_RIGHT;
        if (key_edge[3])      ans_dir = DIR_LEFT;
        else if (key_edge[1]) ans_dir = DIR_UP;
        else if (key_edge[0]) ans_dir = DIR_DOWN;
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        dir_d   = dir_q;
        if (key_edge[4]) begin
            state_d = ST_TEST;
            level_d = 3'd4;
            dir_d   = dir_t'(lfsr_q[1:0]);
        end else if (state_q == ST_TEST && ans_one) begin
            dir_d = dir_t'(lfsr_q[1:0]);
            // The extreme levels do not move further; the answer ends the test instead.
            if (ans_dir == dir_q) begin
                if (level_q == 3'd5) state_d = ST_PASS;
                else                 level_d = level_q + 3'd1;
            end else begin
                if (level_q == 3'd0) state_d = ST_FAIL;
                else                 level_d = level_q - 3'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            lfsr_q  <= LFSR_SEED;
            state_q <= ST_IDLE;
            level_q <= '0;
            dir_q   <= DIR_RIGHT;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            lfsr_q  <= lfsr_d;
            state_q <= state_d;
            level_q <= level_d;
            dir_q   <= dir_d;
        end
    end

    logic [SCW-1:0] scan_cnt_q;
    logic [SGW-1:0] seg_cnt_q;
    logic [2:0]     row_q, dig_q;
    logic [7:0]     col_q, row_pin_q, seg_sel_q, seg_led_q;
    logic [7:0]     pat_row, digit_led;
    logic [3:0]     sz, off, mid, last, lx, ly;
    logic           in_rows, in_cols;

    assign sz   = 4'd8 - {1'b0, level_q};
    assign off  = {2'b00, level_q[2:1]};
    assign mid  = (sz - 4'd1) >> 1;
    assign last = sz - 4'd1;

    // E drawn in box-local coordinates; left/up/down derived by mirroring/transposing "right".
    always_comb begin
        pat_row = '0;
        lx      = '0;
        in_cols = 1'b0;
        ly      = {1'b0, row_q} - off;
        in_rows = ({1'b0, row_q} >= off) && ({1'b0, row_q} < off + sz);
        for (int unsigned c = 0; c < 8; c++) begin
            lx      = c[3:0] - off;
            in_cols = (c[3:0] >= off) && (c[3:0] < off + sz);
            if (state_q == ST_TEST && in_rows && in_cols) begin
                unique case (dir_q)
                    DIR_RIGHT: pat_row[c[2:0]] = (lx == 4'd0) || (ly == 4'd0) || (ly == mid) || (ly == last);
                    DIR_LEFT:  pat_row[c[2:0]] = (lx == last) || (ly == 4'd0) || (ly == mid) || (ly == last);
                    DIR_UP:    pat_row[c[2:0]] = (ly == last) || (lx == 4'd0) || (lx == mid) || (lx == last);
                    DIR_DOWN:  pat_row[c[2:0]] = (ly == 4'd0) || (lx == 4'd0) || (lx == mid) || (lx == last);
                endcase
            end
        end
    end

    always_comb begin
        digit_led = 8'hFF;
        if (state_q == ST_FAIL) begin
            if (dig_q <= 3'd1) digit_led = 8'hBF;
        end else if (state_q == ST_TEST || state_q == ST_PASS) begin
            if (dig_q == 3'd1) begin
                digit_led = (level_q == 3'd5) ? 8'h79 : 8'h40;
            end else if (dig_q == 3'd0) begin
                unique case (level_q)
                    3'd0:    digit_led = 8'hF9;
                    3'd1:    digit_led = 8'hA4;
                    3'd2:    digit_led = 8'h99;
                    3'd3:    digit_led = 8'h82;
                    3'd4:    digit_led = 8'h80;
                    default: digit_led = 8'hC0;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scan_cnt_q <= '0;
            seg_cnt_q  <= '0;
            row_q      <= '0;
            dig_q      <= '0;
            col_q      <= '0;
            row_pin_q  <= '1;
            seg_sel_q  <= '1;
            seg_led_q  <= '1;
        end else begin
            if (scan_cnt_q == SCW'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                row_q      <= row_q + 3'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end
            if (seg_cnt_q == SGW'(SEG_DIV - 1)) begin
                seg_cnt_q <= '0;
                dig_q     <= dig_q + 3'd1;
            end else begin
                seg_cnt_q <= seg_cnt_q + 1'b1;
            end
            row_pin_q <= ~(8'd1 << row_q);
            col_q     <= pat_row;
            seg_sel_q <= ~(8'd1 << dig_q);
            seg_led_q <= digit_led;
        end
    end

    assign io.col_pin = col_q;
    assign io.row_pin = row_pin_q;
    assign io.seg_sel = seg_sel_q;
    assign io.seg_led = seg_led_q;
endmodule

// File: tb/tb_display_sight_test.sv
// Scoreboard bench for display_sight_test: stimulus queues expected digit/row values,
// a monitor waits for the matching scan slot and compares.
module tb_display_sight_test;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_sight_test_if dif();

    display_sight_test #(.SCAN_DIV(4), .SEG_DIV(4), .LFSR_SEED(8'hA5)) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .io(dif)
    );

    typedef struct {
        int         kind;   // 0 = 7-seg digit, 1 = matrix row
        int         idx;
        logic [7:0] exp;
        string      name;
    } exp_t;

    localparam logic [4:0] K_RST = 5'b10000, K_LEFT = 5'b01000, K_RIGHT = 5'b00100,
                           K_UP  = 5'b00010, K_DOWN = 5'b00001;

    // Hand-drawn 4x4 E at offset 2 (level 0.8): right, left, up, down.
    logic [7:0] tbl [4][8] = '{
        '{8'h00, 8'h00, 8'h3C, 8'h3C, 8'h04, 8'h3C, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h3C, 8'h3C, 8'h20, 8'h3C, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h2C, 8'h2C, 8'h2C, 8'h3C, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h3C, 8'h2C, 8'h2C, 8'h2C, 8'h00, 8'h00}
    };

    exp_t       sbq[$];
    bit         mon_busy = 1'b0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] mat [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   found;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                mon_busy = 1'b1;
                e = sbq.pop_front();
                found = 1'b0;
                for (int n = 0; n < 400 && !found; n++) begin
                    if ((e.kind == 0) ? (dif.seg_sel == ~(8'd1 << e.idx))
                                      : (dif.row_pin == ~(8'd1 << e.idx)))
                        found = 1'b1;
                    else
                        @(negedge clk);
                end
                if (!found) begin
                    total++;
                    bad++;
                    $display("FAIL %s: scan slot %0d never selected, expected %h", e.name, e.idx, e.exp);
                end else begin
                    check(e.name, (e.kind == 0) ? dif.seg_led : dif.col_pin, e.exp);
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic push(input int kind, input int idx, input logic [7:0] v, input string nm);
        exp_t e;
        e.kind = kind; e.idx = idx; e.exp = v; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic expect_disp(input logic [7:0] d1, input logic [7:0] d0, input string nm);
        push(0, 1, d1, {nm, ".digit1"});
        push(0, 0, d0, {nm, ".digit0"});
        push(0, 2, 8'hFF, {nm, ".digit2"});
        push(0, 7, 8'hFF, {nm, ".digit7"});
    endtask

    task automatic expect_blank_matrix(input string nm);
        for (int r = 0; r < 8; r++) push(1, r, 8'h00, nm);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || mon_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || mon_busy) begin
            total++;
            bad++;
            $display("FAIL drain: %0d items left, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] k, input int n);
        @(negedge clk);
        {dif.KeyRESTART, dif.KeyLeft, dif.KeyRight, dif.Keyup, dif.KeyDown} = k;
        repeat (n) @(negedge clk);
        {dif.KeyRESTART, dif.KeyLeft, dif.KeyRight, dif.Keyup, dif.KeyDown} = 5'b0;
    endtask

    function automatic logic [4:0] dir_key(input int d);
        case (d)
            1:       return K_LEFT;
            2:       return K_UP;
            3:       return K_DOWN;
            default: return K_RIGHT;
        endcase
    endfunction

    task automatic read_digit(input int idx, output logic [7:0] v);
        v = 8'hxx;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (dif.seg_sel == ~(8'd1 << idx)) begin
                v = dif.seg_led;
                break;
            end
        end
    endtask

    task automatic grab_matrix();
        bit got;
        for (int r = 0; r < 8; r++) begin
            got = 1'b0;
            mat[r] = 8'h00;
            for (int n = 0; n < 400 && !got; n++) begin
                @(negedge clk);
                if (dif.row_pin == ~(8'd1 << r)) begin
                    mat[r] = dif.col_pin;
                    got = 1'b1;
                end
            end
        end
    endtask

    // Identify the E from its outline: which box edges are solid bars.
    function automatic void classify(output int dir, output int size);
        int  rmin, rmax, cmin, cmax;
        bit  colL, colR, rowT, rowB;
        rmin = 8; rmax = -1; cmin = 8; cmax = -1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (mat[r][c]) begin
                    if (r < rmin) rmin = r;
                    if (r > rmax) rmax = r;
                    if (c < cmin) cmin = c;
                    if (c > cmax) cmax = c;
                end
        dir = -1;
        size = 0;
        if (rmax < 0) return;
        size = rmax - rmin + 1;
        colL = 1'b1; colR = 1'b1; rowT = 1'b1; rowB = 1'b1;
        for (int r = rmin; r <= rmax; r++) begin
            if (!mat[r][cmin]) colL = 1'b0;
            if (!mat[r][cmax]) colR = 1'b0;
        end
        for (int c = cmin; c <= cmax; c++) begin
            if (!mat[rmin][c]) rowT = 1'b0;
            if (!mat[rmax][c]) rowB = 1'b0;
        end
        if (colL && colR) begin
            if (rowT && !rowB)      dir = 3;
            else if (rowB && !rowT) dir = 2;
        end else if (colL) begin
            dir = 0;
        end else if (colR) begin
            dir = 1;
        end
    endfunction

    task automatic observe(input int want_size, input string nm, output int d);
        int sz;
        grab_matrix();
        classify(d, sz);
        total++;
        if (d < 0 || sz != want_size) begin
            bad++;
            $display("FAIL %s: E size %0d dir %0d, expected size %0d with a recognisable opening",
                     nm, sz, d, want_size);
        end
    endtask

    logic [7:0] lv_d1 [5] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'hBF};
    logic [7:0] lv_d0 [5] = '{8'h82, 8'h99, 8'hA4, 8'hF9, 8'hBF};

    initial begin : stimulus
        int         d;
        int         g;
        bit         passed;
        logic [7:0] v;

        {dif.KeyRESTART, dif.KeyLeft, dif.KeyRight, dif.Keyup, dif.KeyDown} = 5'b0;
        rst = 1'b1;
        wait_clk(4);
        check("reset.col_pin", dif.col_pin, 8'h00);
        check("reset.row_pin", dif.row_pin, 8'hFF);
        check("reset.seg_sel", dif.seg_sel, 8'hFF);
        check("reset.seg_led", dif.seg_led, 8'hFF);
        rst = 1'b0;
        expect_blank_matrix("idle.row");
        for (int k = 0; k < 8; k++) push(0, k, 8'hFF, "idle.digit");
        drain();

        // Start: 0.8 with a 4x4 E at offset 2
        press(K_RST, 2);
        wait_clk(80);
        expect_disp(8'h40, 8'h80, "start");
        observe(4, "start.shape", d);
        if (d >= 0)
            for (int r = 0; r < 8; r++) push(1, r, tbl[d][r], "start.row");
        drain();

        // Wrong answers walk down to 0.1, then FAIL
        for (int k = 0; k < 5; k++) begin
            observe(4 + k, "down.shape", d);
            press(dir_key((d < 0) ? 0 : (d + 1) % 4), 1);
            wait_clk(100);
            expect_disp(lv_d1[k], lv_d0[k], "down.level");
            drain();
        end
        expect_blank_matrix("fail.row");
        press(K_LEFT, 1);
        wait_clk(100);
        expect_disp(8'hBF, 8'hBF, "fail.sixth");
        drain();

        // Correct answers: 0.8 -> 1.0 -> PASS
        press(K_RST, 2);
        wait_clk(80);
        expect_disp(8'h40, 8'h80, "restart");
        drain();
        observe(4, "up.shape", d);
        press(dir_key((d < 0) ? 0 : d), 1);
        wait_clk(100);
        expect_disp(8'h79, 8'hC0, "level1.0");
        for (int r = 0; r < 8; r++) push(1, r, (r >= 2 && r <= 4) ? 8'h1C : 8'h00, "level1.0.row");
        drain();
        // A 3x3 E is a solid block, so the 1.0 answer is guessed until it lands
        passed = 1'b0;
        g = 0;
        for (int a = 0; a < 40 && !passed; a++) begin
            press(dir_key(g), 1);
            g = (g + 1) % 4;
            wait_clk(100);
            read_digit(0, v);
            if (v === 8'hC0) begin
                passed = 1'b1;
            end else begin
                observe(4, "retry.shape", d);
                press(dir_key((d < 0) ? 0 : d), 1);
                wait_clk(100);
            end
        end
        check("pass.reached", {7'b0, passed}, 8'h01);
        expect_disp(8'h79, 8'hC0, "pass");
        expect_blank_matrix("pass.row");
        drain();
        press(K_UP, 1);
        wait_clk(100);
        expect_disp(8'h79, 8'hC0, "pass.key_ignored");
        drain();

        // Reset mid-test acts asynchronously
        press(K_RST, 2);
        wait_clk(60);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst.col_pin", dif.col_pin, 8'h00);
        check("midrst.row_pin", dif.row_pin, 8'hFF);
        check("midrst.seg_sel", dif.seg_sel, 8'hFF);
        check("midrst.seg_led", dif.seg_led, 8'hFF);
        wait_clk(3);
        rst = 1'b0;
        expect_disp(8'hFF, 8'hFF, "midrst.idle");
        expect_blank_matrix("midrst.row");
        drain();
        press(K_RST, 2);
        wait_clk(80);
        expect_disp(8'h40, 8'h80, "midrst.restart");
        drain();

        // Simultaneous edges
        press(K_UP | K_DOWN, 1);
        wait_clk(100);
        expect_disp(8'h40, 8'h80, "updown.ignored");
        drain();
        press(K_RST | K_LEFT, 1);
        wait_clk(100);
        expect_disp(8'h40, 8'h80, "restart_wins");
        drain();
        observe(4, "restart_wins.shape", d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
